// File: rtl/instr_fetch.sv
// Instruction fetch unit: a three-state sequencer that fetches one word from
// instruction memory, holds it for the datapath, and then advances or branches the PC.
module instr_fetch #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [31:0] RESET_INSTR = 32'h0
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [10:0] opcode,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        uncond_branch,
  input  logic        zero,
  input  logic [63:0] sign_ext_imm,
  output logic [63:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [63:0] pc_next;
  logic [31:0] instr_next;
  logic        taken;
  logic [63:0] branch_target;
  logic [63:0] seq_target;

  // Offset is in words; the shift and both adds wrap silently at 2^64.
  assign branch_target = pc + {sign_ext_imm[61:0], 2'b00};
  assign seq_target    = pc + 64'd4;
  assign taken         = uncond_branch | (branch & zero);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_next  = instr;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_next = imem_data;
          state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (ex_done) begin
          pc_next    = taken ? branch_target : seq_target;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= RESET_INSTR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:21];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter RESET_INSTR, default 32'h0, instruction register value loaded on reset.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  64  fetch byte address, equal to pc.
REQ-007 imem_ack  input  1  memory returns imem_data this cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 instr  output  32  registered current instruction.
REQ-010 opcode  output  11  instr[31:21], consumed by the control decoder.
REQ-011 instr_valid  output  1  instr/opcode hold a fetched instruction awaiting execution.
REQ-012 ex_done  input  1  datapath has finished the current instruction this cycle.
REQ-013 branch  input  1  conditional branch (CBZ) from control.
REQ-014 uncond_branch  input  1  unconditional branch (B) from control.
REQ-015 zero  input  1  ALU zero flag.
REQ-016 sign_ext_imm  input  64  sign-extended branch offset in words.
REQ-017 pc  output  64  current program counter.

Function
REQ-018 FSM states: IDLE, FETCH, EXEC; encoding free, at most 2 flops.
REQ-019 IDLE: imem_req=0, instr_valid=0; always -> FETCH next cycle.
REQ-020 FETCH: imem_req=1, imem_addr=pc; hold state and pc while imem_ack=0 (unbounded wait).
REQ-021 FETCH with imem_ack=1: instr <= imem_data; -> EXEC; imem_req deasserts next cycle.
REQ-022 EXEC: imem_req=0, instr_valid=1; instr, opcode, pc stable until ex_done.
REQ-023 EXEC with ex_done=1: update pc per REQ-024; -> FETCH.
REQ-024 Next pc: taken = uncond_branch | (branch & zero); taken -> pc + (sign_ext_imm << 2); else pc + 4.
REQ-025 PC arithmetic 64-bit modulo 2^64; carries out of bit 63 discarded (wrap, no flag).
REQ-026 Branch/zero/imm sampled only in the ex_done cycle of EXEC; ignored otherwise.
REQ-027 imem_ack outside FETCH ignored; no instr or state change.
REQ-028 ex_done outside EXEC ignored; pc unchanged.
REQ-029 ex_done in the cycle after entering EXEC legal (minimum 1-cycle EXEC).
REQ-030 Minimum loop: FETCH(ack) 1 cycle + EXEC 1 cycle = 2 cycles per instruction.
REQ-031 opcode combinationally equals instr[31:21] in all states.
REQ-032 Outputs imem_req, instr_valid decoded from state only (Moore); no input-to-output combinational path except imem_addr=pc.

Reset
REQ-033 reset=1 at rising edge: state <= IDLE, pc <= RESET_PC, instr <= RESET_INSTR; overrides all other inputs.
REQ-034 Reset mid-FETCH or mid-EXEC: pending ack/ex_done in that cycle discarded; no pc update.
REQ-035 After reset deasserts: IDLE 1 cycle, first imem_req on 2nd cycle with imem_addr=RESET_PC.
REQ-036 Outputs during/after reset: imem_req=0, instr_valid=0, pc=RESET_PC, instr=RESET_INSTR.

Verification
REQ-037 Sequential: reset, ack immediately, ex_done with branch=0 -> fetch addresses 0x0, 0x4, 0x8; instr_valid pulses 1 cycle each.
REQ-038 CBZ taken: pc=0x10, branch=1, zero=1, imm=64'd3, ex_done -> next imem_addr=0x1C; with zero=0 -> 0x14.
REQ-039 B backward: pc=0x20, uncond_branch=1, imm=64'hFFFF_FFFF_FFFF_FFFE -> next pc=0x18; pc=64'hFFFF_FFFF_FFFF_FFFC, sequential -> pc=0x0 (wrap).
REQ-040 Memory stall: ack held 0 for 5 cycles -> imem_req=1 and imem_addr constant throughout; instr latched only on ack cycle with imem_data=32'h8B02_0020 -> opcode=11'h458.
REQ-041 Spurious signals: ack asserted in EXEC with different data -> instr unchanged; ex_done in FETCH -> pc unchanged.
REQ-042 Reset mid-EXEC coincident with ex_done and branch taken -> pc=RESET_PC, instr_valid=0, IDLE then FETCH at RESET_PC.
